// File: rtl/abs_frame_sink.sv
// abs_frame_sink: captures FRAME_LEN-sample frames of magnitude data into a two-bank
// ping-pong buffer, tracks each frame's peak and its index, and offers the oldest full
// bank for random-access readback while the other bank fills.
module abs_frame_sink #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              val_i,
  input  logic [DATA_W-1:0] abs_i,
  output logic              frame_done_o,
  output logic [DATA_W-1:0] peak_o,
  output logic [ADDR_W-1:0] peak_idx_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic              rd_rdy_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_val_o,
  input  logic              rd_release_i,
  output logic              overflow_o
);

  localparam logic [1:0] BankEmpty   = 2'd0;
  localparam logic [1:0] BankFilling = 2'd1;
  localparam logic [1:0] BankFull    = 2'd2;

  logic [1:0]        bank_st_q [2];
  logic [1:0]        bank_st_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] run_peak_q, run_peak_d;
  logic [ADDR_W-1:0] run_idx_q, run_idx_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [ADDR_W-1:0] peak_idx_q, peak_idx_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              rd_rdy_q, rd_rdy_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_val_q;

  logic              wr_full;
  logic              wr_acc;
  logic              wr_last;
  logic              new_max;
  logic              rd_go;

  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  assign wr_full = (bank_st_q[wr_bank_q] == BankFull);
  assign wr_acc  = val_i && !wr_full;
  assign wr_last = (wr_idx_q == ADDR_W'(FRAME_LEN - 1));
  // The first sample of a frame always seeds the peak; afterwards strictly greater wins.
  assign new_max = (wr_idx_q == '0) || (abs_i > run_peak_q);
  assign rd_go   = rd_en_i && rd_rdy_q;

  // Next-state for bank bookkeeping, peak tracking and frame completion.
  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;
    run_peak_d   = run_peak_q;
    run_idx_d    = run_idx_q;
    frame_done_d = 1'b0;
    peak_d       = peak_q;
    peak_idx_d   = peak_idx_q;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q;

    if (val_i && wr_full) begin
      overflow_d = 1'b1;
    end

    if (wr_acc) begin
      if (new_max) begin
        run_peak_d = abs_i;
        run_idx_d  = wr_idx_q;
      end
      if (wr_last) begin
        frame_done_d         = 1'b1;
        peak_d               = new_max ? abs_i : run_peak_q;
        peak_idx_d           = new_max ? wr_idx_q : run_idx_q;
        frame_cnt_d          = frame_cnt_q + FCNT_W'(1);
        bank_st_d[wr_bank_q] = BankFull;
        wr_bank_d            = ~wr_bank_q;
        wr_idx_d             = '0;
        run_peak_d           = '0;
        run_idx_d            = '0;
      end else begin
        bank_st_d[wr_bank_q] = BankFilling;
        wr_idx_d             = wr_idx_q + ADDR_W'(1);
      end
    end

    // A full read bank can never be the accepting write bank, so these never collide.
    if (rd_release_i && rd_rdy_q) begin
      bank_st_d[rd_bank_q] = BankEmpty;
      rd_bank_d            = ~rd_bank_q;
    end

    rd_rdy_d = (bank_st_d[rd_bank_d] == BankFull);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st_q[0] <= BankEmpty;
      bank_st_q[1] <= BankEmpty;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      run_peak_q   <= '0;
      run_idx_q    <= '0;
      frame_done_q <= 1'b0;
      peak_q       <= '0;
      peak_idx_q   <= '0;
      frame_cnt_q  <= '0;
      rd_rdy_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      run_peak_q   <= run_peak_d;
      run_idx_q    <= run_idx_d;
      frame_done_q <= frame_done_d;
      peak_q       <= peak_d;
      peak_idx_q   <= peak_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      rd_rdy_q     <= rd_rdy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Buffer write port; contents are deliberately left uninitialised.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[{wr_bank_q, wr_idx_q}] <= abs_i;
    end
  end

  // Buffer read port; uses the pre-release rd_bank so a same-cycle release still reads it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_val_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_val_q <= rd_go;
      if (rd_go) begin
        rd_data_q <= mem[{rd_bank_q, rd_addr_i}];
      end
    end
  end

  assign frame_done_o = frame_done_q;
  assign peak_o       = peak_q;
  assign peak_idx_o   = peak_idx_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign rd_rdy_o     = rd_rdy_q;
  assign rd_data_o    = rd_data_q;
  assign rd_val_o     = rd_val_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_abs_frame_sink.sv
// Bench for abs_frame_sink: a behavioural model of the ping-pong sink pushes expected
// frame results and read data to queues; a negedge monitor pops and compares them.
module tb_abs_frame_sink;

  localparam int FL = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       val_i;
  logic [7:0] abs_i;
  logic       frame_done_o;
  logic [7:0] peak_o;
  logic [9:0] peak_idx_o;
  logic [15:0] frame_cnt_o;
  logic       rd_rdy_o;
  logic       rd_en_i;
  logic [9:0] rd_addr_i;
  logic [7:0] rd_data_o;
  logic       rd_val_o;
  logic       rd_release_i;
  logic       overflow_o;

  abs_frame_sink #(
    .DATA_W   (8),
    .FRAME_LEN(FL),
    .ADDR_W   (10),
    .FCNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .val_i       (val_i),
    .abs_i       (abs_i),
    .frame_done_o(frame_done_o),
    .peak_o      (peak_o),
    .peak_idx_o  (peak_idx_o),
    .frame_cnt_o (frame_cnt_o),
    .rd_rdy_o    (rd_rdy_o),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_val_o    (rd_val_o),
    .rd_release_i(rd_release_i),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  typedef struct {
    int          due;
    logic [7:0]  peak;
    logic [9:0]  idx;
    logic [15:0] cnt;
  } fr_t;

  rd_t rq[$];
  fr_t fq[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: 0 empty, 1 filling, 2 full.
  int         m_st[2];
  logic       m_wr, m_rd, m_rdy, m_ovf;
  int         m_idx;
  logic [7:0] m_peak;
  logic [9:0] m_pidx;
  logic [15:0] m_cnt;
  logic [7:0] m_mem[2][FL];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st[0] = 0; m_st[1] = 0;
    m_wr = 0; m_rd = 0; m_rdy = 0; m_ovf = 0;
    m_idx = 0; m_peak = 0; m_pidx = 0; m_cnt = 0;
  endtask

  // One clock of stimulus; returns #1 after the capturing edge.
  task automatic step(input logic v, input logic [7:0] a, input logic re,
                      input logic [9:0] ra, input logic rel);
    logic acc;
    val_i = v; abs_i = a; rd_en_i = re; rd_addr_i = ra; rd_release_i = rel;
    if (re && m_rdy) rq.push_back('{due: cyc + 1, data: m_mem[m_rd][ra]});
    acc = v && (m_st[m_wr] != 2);
    if (v && !acc) m_ovf = 1;
    if (acc) begin
      m_mem[m_wr][m_idx] = a;
      if (m_idx == 0 || a > m_peak) begin
        m_peak = a;
        m_pidx = 10'(m_idx);
      end
      if (m_idx == FL - 1) begin
        m_cnt++;
        fq.push_back('{due: cyc + 1, peak: m_peak, idx: m_pidx, cnt: m_cnt});
        m_st[m_wr] = 2;
        m_wr = ~m_wr;
        m_idx = 0;
        m_peak = 0;
      end else begin
        m_st[m_wr] = 1;
        m_idx++;
      end
    end
    if (rel && m_rdy) begin
      m_st[m_rd] = 0;
      m_rd = ~m_rd;
    end
    m_rdy = (m_st[m_rd] == 2);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 0; val_i = 0; abs_i = 0; rd_en_i = 0; rd_addr_i = 0; rd_release_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, frame_done_o, 0);
    chk({tag, "_peak"}, peak_o, 0);
    chk({tag, "_idx"}, peak_idx_o, 0);
    chk({tag, "_cnt"}, frame_cnt_o, 0);
    chk({tag, "_rdy"}, rd_rdy_o, 0);
    chk({tag, "_rdval"}, rd_val_o, 0);
    chk({tag, "_rddata"}, rd_data_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
  endtask

  // Scoreboard: compares at every cycle where the DUT or the model expects activity.
  always @(negedge clk) begin
    logic ev;
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    if (ev || rd_val_o === 1'b1) begin
      chk("rd_val", rd_val_o, ev);
      if (ev) begin
        chk("rd_data", rd_data_o, rq[0].data);
        void'(rq.pop_front());
      end
    end
    ev = (fq.size() > 0) && (fq[0].due == cyc);
    if (ev || frame_done_o === 1'b1) begin
      chk("frame_done", frame_done_o, ev);
      if (ev) begin
        chk("peak", peak_o, fq[0].peak);
        chk("peak_idx", peak_idx_o, fq[0].idx);
        chk("frame_cnt", frame_cnt_o, fq[0].cnt);
        void'(fq.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] d;
    // Reset
    do_reset();
    do_reset();
    chk_zero("reset");

    // T1: ramp frame
    for (int i = 0; i < FL; i++) step(1'b1, 8'(i), 1'b0, 10'd0, 1'b0);
    chk("t1_done", frame_done_o, 1);
    chk("t1_peak", peak_o, 8'd255);
    chk("t1_idx", peak_idx_o, 10'd255);
    chk("t1_cnt", frame_cnt_o, 1);
    chk("t1_rdy", rd_rdy_o, 1);
    idle();
    chk("t1_done_pulse", frame_done_o, 0);

    // T2: back-to-back readback
    for (int i = 0; i < FL; i++) step(1'b0, 8'h00, 1'b1, 10'(i), 1'b0);
    idle();
    chk("t2_rdval_end", rd_val_o, 0);
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b1);
    chk("t2_rdy_released", rd_rdy_o, 0);
    // Read while not ready: no valid, data holds
    step(1'b0, 8'h00, 1'b1, 10'd3, 1'b0);
    idle();
    chk("t2_noread_val", rd_val_o, 0);
    chk("t2_noread_hold", rd_data_o, 8'hFF);

    // T3: two equal peaks, earliest wins
    for (int i = 0; i < FL; i++)
      step(1'b1, (i == 5 || i == 700) ? 8'h80 : 8'h10, 1'b0, 10'd0, 1'b0);
    chk("t3_peak", peak_o, 8'h80);
    chk("t3_idx", peak_idx_o, 10'd5);
    chk("t3_cnt", frame_cnt_o, 2);
    step(1'b0, 8'h00, 1'b1, 10'd700, 1'b1);
    idle();

    // T4: three frames without release
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FL; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 10'd0, 1'b0);
    idle();
    chk("t4_ovf", overflow_o, 1);
    chk("t4_cnt", frame_cnt_o, 4);
    chk("t4_rdy", rd_rdy_o, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 10'($urandom_range(0, FL - 1)), 1'b0);
    step(1'b0, 8'h00, 1'b1, 10'd1023, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 10'($urandom_range(0, FL - 1)), 1'b0);
    for (int i = 0; i < FL; i++) step(1'b1, 8'(i * 3 + 1), 1'b0, 10'd0, 1'b0);
    idle();
    chk("t4_cnt_resume", frame_cnt_o, 5);
    step(1'b0, 8'h00, 1'b0, 10'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 10'(i * 97), 1'b0);
    idle();
    chk("t4_ovf_sticky", overflow_o, 1);

    // T5: reset, then continuous 4-frame stream releasing on each later last sample
    do_reset();
    chk_zero("t5_reset");
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < FL; i++) begin
        d = 8'((i * 7 + f * 13) % 256);
        step(1'b1, d, (f >= 1 && i == FL - 1), 10'(i - f), (f >= 1 && i == FL - 1));
      end
    idle();
    chk("t5_ovf", overflow_o, 0);
    chk("t5_cnt", frame_cnt_o, 4);
    chk("t5_rdy", rd_rdy_o, 1);

    // T6: reset mid-frame
    for (int i = 0; i < 500; i++) step(1'b1, 8'(i), 1'b0, 10'd0, 1'b0);
    do_reset();
    chk_zero("t6_reset");
    for (int i = 0; i < FL; i++) step(1'b1, 8'(255 - (i % 200)), 1'b0, 10'd0, 1'b0);
    chk("t6_done", frame_done_o, 1);
    chk("t6_cnt", frame_cnt_o, 1);
    idle();
    idle();

    chk("rd_queue_drained", rq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
